// File: rtl/ta_drrip_cache.sv
// Thread-aware DRRIP replacement controller.
// Tracks per-set/per-way RRPVs, one PSEL duel counter per thread, and a shared
// BIP throttle counter. Hits promote a way in one edge; a miss walks
// SEARCH/AGE until a way at the maximum RRPV is found, then inserts into it.
module ta_drrip_cache #(
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = 64,
  parameter int RRPV_BITS       = 2,
  parameter int NUM_THREADS     = 2,
  parameter int PSEL_BITS       = 10,
  parameter int BIP_THROTTLE    = 32,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid,
  input  logic                             hit,
  input  logic                             miss,
  input  logic [SET_INDEX_WIDTH-1:0]       set_index,
  input  logic [3:0]                       access_way,
  input  logic [3:0]                       thread_id,
  output logic                             req_ready,
  output logic [3:0]                       victim_way,
  output logic                             victim_ready,
  output logic [NUM_THREADS*PSEL_BITS-1:0] psel_counters,
  output logic [NUM_THREADS-1:0]           policy_bip
);

  localparam int BIPW = (BIP_THROTTLE > 1) ? $clog2(BIP_THROTTLE) : 1;
  localparam logic [RRPV_BITS-1:0] RRPV_MAX  = {RRPV_BITS{1'b1}};
  localparam logic [RRPV_BITS-1:0] RRPV_LONG = RRPV_MAX - RRPV_BITS'(1);
  localparam logic [PSEL_BITS-1:0] PSEL_INIT = {1'b0, {(PSEL_BITS-1){1'b1}}};
  localparam logic [BIPW-1:0]      BIP_LAST  = BIPW'(BIP_THROTTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_AGE, S_INSERT} state_t;
  typedef enum logic [1:0] {L_FOLLOW, L_SRRIP, L_BIP} lead_t;

  state_t                     r_state, w_state_nxt;
  logic [SET_INDEX_WIDTH-1:0] r_set;
  logic [3:0]                 r_tid;
  lead_t                      r_lead;
  logic [3:0]                 r_victim;
  logic [RRPV_BITS-1:0]       r_rrpv [NUM_SETS][NUM_WAYS];
  logic [PSEL_BITS-1:0]       r_psel [NUM_THREADS];
  logic [BIPW-1:0]            r_bip_cnt;
  logic [3:0]                 r_victim_way;
  logic                       r_victim_ready;

  logic                       w_accept;
  logic                       w_found;
  logic [3:0]                 w_victim;
  logic [PSEL_BITS-1:0]       w_psel_sel;
  logic                       w_ins_bip;
  logic [RRPV_BITS-1:0]       w_ins_val;

  // Leader class of a set as seen by the requesting thread; sets leading
  // only for other threads are followers for this one.
  function automatic lead_t f_leader(input logic [SET_INDEX_WIDTH-1:0] s,
                                     input logic [3:0] t);
    logic [4:0] k;
    k = s[4:0];
    if (k == {t, 1'b0})      return L_SRRIP;
    else if (k == {t, 1'b1}) return L_BIP;
    else                     return L_FOLLOW;
  endfunction

  function automatic logic [PSEL_BITS-1:0] f_sat_inc(input logic [PSEL_BITS-1:0] v);
    return (&v) ? v : v + PSEL_BITS'(1);
  endfunction

  function automatic logic [PSEL_BITS-1:0] f_sat_dec(input logic [PSEL_BITS-1:0] v);
    return (v == '0) ? v : v - PSEL_BITS'(1);
  endfunction

  assign w_accept = valid && req_ready && (hit ^ miss) &&
                    ({1'b0, thread_id} < 5'(NUM_THREADS)) &&
                    (miss || ({1'b0, access_way} < 5'(NUM_WAYS)));

  // Victim search in the latched set, requester's PSEL and insertion value
  always_comb begin
    w_found    = 1'b0;
    w_victim   = '0;
    w_psel_sel = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_rrpv[r_set][w] == RRPV_MAX) begin
        w_found  = 1'b1;
        w_victim = 4'(w);
      end
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (4'(t) == r_tid) w_psel_sel = r_psel[t];
    end
    w_ins_bip = (r_lead == L_BIP) || ((r_lead == L_FOLLOW) && w_psel_sel[PSEL_BITS-1]);
    w_ins_val = RRPV_LONG;
    if (w_ins_bip && (r_bip_cnt != BIP_LAST)) w_ins_val = RRPV_MAX;
  end

  // Miss FSM next state and request handshake
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept && miss) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: w_state_nxt = w_found ? S_INSERT : S_AGE;
      S_AGE:    w_state_nxt = S_SEARCH;
      S_INSERT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Miss context latched on acceptance; victim latched when search succeeds
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept && miss) begin
      r_set  <= set_index;
      r_tid  <= thread_id;
      r_lead <= f_leader(set_index, thread_id);
    end
    if (r_state == S_SEARCH && w_found) r_victim <= w_victim;
  end

  // RRPV table: promote on hit, age the set, write the insertion value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          r_rrpv[s][w] <= RRPV_MAX;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && hit) begin
            for (int w = 0; w < NUM_WAYS; w++)
              if (4'(w) == access_way) r_rrpv[set_index][w] <= '0;
          end
        end
        S_AGE: begin
          for (int w = 0; w < NUM_WAYS; w++)
            r_rrpv[r_set][w] <= r_rrpv[r_set][w] + RRPV_BITS'(1);
        end
        S_INSERT: begin
          for (int w = 0; w < NUM_WAYS; w++)
            if (4'(w) == r_victim) r_rrpv[r_set][w] <= w_ins_val;
        end
        default: ;
      endcase
    end
  end

  // Victim outputs: one-cycle pulse, way held until the next insertion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_victim_ready <= 1'b0;
      r_victim_way   <= '0;
    end else begin
      r_victim_ready <= (r_state == S_INSERT);
      if (r_state == S_INSERT) r_victim_way <= r_victim;
    end
  end

  // Set-dueling PSEL counters and shared BIP throttle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) r_psel[t] <= PSEL_INIT;
      r_bip_cnt <= '0;
    end else if (r_state == S_INSERT) begin
      if (w_ins_bip) r_bip_cnt <= r_bip_cnt + BIPW'(1);
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (4'(t) == r_tid) begin
          if (r_lead == L_SRRIP)    r_psel[t] <= f_sat_inc(r_psel[t]);
          else if (r_lead == L_BIP) r_psel[t] <= f_sat_dec(r_psel[t]);
        end
      end
    end
  end

  // Flatten PSELs and derive each thread's follower policy
  always_comb begin
    psel_counters = '0;
    policy_bip    = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      psel_counters[t*PSEL_BITS +: PSEL_BITS] = r_psel[t];
      policy_bip[t] = r_psel[t][PSEL_BITS-1];
    end
  end

  assign victim_way   = r_victim_way;
  assign victim_ready = r_victim_ready;

endmodule

// File: doc/ta_drrip_cache.md
TA_DRRIP_CACHE -- requirements
Module: ta_drrip_cache

Interface
REQ-001 SHALL have parameters: NUM_WAYS 4, ways per set (2..16); NUM_SETS 64, sets (power of 2, >=32); RRPV_BITS 2, RRPV width; NUM_THREADS 2, thread count (1..16); PSEL_BITS 10, per-thread PSEL width; BIP_THROTTLE 32, BIP long-insertion period (power of 2); SET_INDEX_WIDTH $clog2(NUM_SETS).
REQ-002 SHALL have ports, in order:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- valid  in  1  request present
- hit  in  1  request is a hit
- miss  in  1  request is a miss
- set_index  in  SET_INDEX_WIDTH  target set
- access_way  in  4  way hit
- thread_id  in  4  requesting thread
- req_ready  out  1  request accepted this edge when high
- victim_way  out  4  selected victim
- victim_ready  out  1  one-cycle victim-valid pulse
- psel_counters  out  NUM_THREADS*PSEL_BITS  PSEL per thread; thread t at bits [t*PSEL_BITS +: PSEL_BITS]
- policy_bip  out  NUM_THREADS  follower policy per thread; 1 = BIP

Function
REQ-003 MAX = 2^RRPV_BITS-1. SRRIP insertion value = MAX-1. BIP insertion value = MAX-1 when bip_counter == BIP_THROTTLE-1, else MAX.
REQ-004 Leader map: k = set_index mod 32. k == 2t: SRRIP leader of thread t. k == 2t+1: BIP leader of thread t. All other sets are followers. A set that leads only for another thread is a follower for the requester.
REQ-005 Follower policy for thread t: BIP when PSEL[t] >= 2^(PSEL_BITS-1), else SRRIP. policy_bip[t] mirrors this combinationally.
REQ-006 Request accepted at an edge when valid && req_ready && exactly one of hit/miss is set && thread_id < NUM_THREADS. Any other request is ignored with no state change. A hit also requires access_way < NUM_WAYS.
REQ-007 Hit: rrpv[set][access_way] <= 0 at the accepting edge. No victim_ready. No PSEL or bip_counter change. req_ready stays high.
REQ-008 Miss FSM: IDLE -> SEARCH -> INSERT -> IDLE, with SEARCH -> AGE -> SEARCH when no way in the set has RRPV == MAX.
- Accepting edge: latch set, thread, leader class; go to SEARCH.
- req_ready = 1 only in IDLE.
REQ-009 SEARCH: victim = lowest-indexed way with RRPV == MAX; go to INSERT. If none, go to AGE.
REQ-010 AGE: add 1 to every way's RRPV in the latched set (never overflows).
REQ-011 INSERT edge:
- write the insertion value (leader policy, or the thread's follower policy) to rrpv[set][victim];
- drive victim_way;
- pulse victim_ready for exactly one cycle;
- return to IDLE.
REQ-012 INSERT edge, counter updates:
- SRRIP leader of the requester: PSEL[t] += 1, saturating at 2^PSEL_BITS-1.
- BIP leader of the requester: PSEL[t] -= 1, saturating at 0.
- bip_counter (shared, modulo BIP_THROTTLE) increments on every BIP-policy insertion.
REQ-013 Latency, with A = number of aging rounds (0..MAX): victim_ready rises at edge E+2+2A after accepting edge E. req_ready is high again in the same cycle.
REQ-014 victim_way holds its value until the next INSERT.

Reset
REQ-015 On rst at any edge:
- every RRPV = MAX;
- each PSEL = 2^(PSEL_BITS-1)-1 (511);
- bip_counter = 0;
- FSM = IDLE; victim_way = 0; victim_ready = 0; req_ready = 1.
REQ-016 Reset mid-miss (SEARCH/AGE/INSERT) aborts the miss: no victim_ready pulse, no partial counter update survives.

Verification (defaults)
REQ-017 Reset; thread 0 misses set 0 -> victim_way 0 at E+2; rrpv[0][0] = 2; PSEL0 = 512; policy_bip[0] = 1; PSEL1 = 511.
REQ-018 Four more thread-0 misses on set 0 -> victims 1, 2, 3 with no aging. The 5th miss ages once (all RRPVs 2->3) and yields victim 0 at E+4. PSEL0 = 516.
REQ-019 Thread 1 hits set 5 way 1 -> rrpv[5][1] = 0 after one edge; no victim_ready; PSELs unchanged.
REQ-020 Thirty-two thread-0 misses on set 1 from reset -> insertions are 3 for misses 1..31 and 2 for the 32nd; bip_counter wraps to 0. Continue to 520 misses total -> PSEL0 saturates at 0 and holds.
REQ-021 Thread 0 misses set 2 (thread 1's SRRIP leader) -> follower behaviour for thread 0; PSEL1 unchanged.
REQ-022 Assert rst during AGE -> victim_ready never pulses; PSELs = 511; req_ready = 1 on the next cycle. Requests with valid && hit && miss -> ignored; no state change.
